seq_divider: RTL
================

# seq_divider

Multi-cycle radix-2 restoring integer divider: the responder side of the dividend/divisor/dout stream interface that the divide functional unit drives. It latches one operand pair when both input valids are high, iterates one quotient bit per cycle, then pulses a single result beat of `{quotient, remainder}`. It replaces the vendor divider core inside the divide FU with identical port semantics and fixed, data-independent latency.

## Interface
- `WIDTH`, 32, operand width; result is `2*WIDTH`.
- `SIGNED`, 1, 1 = two's-complement division, 0 = unsigned.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_axis_dividend_tvalid` in 1: dividend valid.
- `s_axis_dividend_tdata` in WIDTH: dividend.
- `s_axis_divisor_tvalid` in 1: divisor valid.
- `s_axis_divisor_tdata` in WIDTH: divisor.
- `m_axis_dout_tvalid` out 1: one-cycle result pulse.
- `m_axis_dout_tdata` out 2*WIDTH: `[2W-1:W]` quotient, `[W-1:0]` remainder.
- `busy` out 1: high in CALC and DONE.

## Operation
- No tready on any channel. Inputs are accepted only in IDLE, and only when both tvalids are high in the same cycle. A single valid alone is ignored. Inputs are ignored in every other state; upstream may hold valids high throughout.
- States:
  - IDLE: on acceptance, latch the operands, compute magnitudes and result signs, clear the remainder and the count, go to CALC.
  - CALC: exactly WIDTH cycles. Each cycle: `r' = {r[W-1:0], q_msb}`. If `r' >= |divisor|`, subtract and shift in quotient bit 1, else shift in 0. The remainder register is WIDTH+1 bits. After WIDTH iterations, go to DONE.
  - DONE: one cycle, `m_axis_dout_tvalid=1`. Next state is IDLE unconditionally. No acceptance on this edge, even if valids are high.
- Signed rules (SIGNED=1):
  - The quotient truncates toward zero. The remainder takes the sign of the dividend.
  - Magnitudes are formed as WIDTH-bit unsigned, so |−2^(W−1)| = 2^(W−1) is representable.
  - Signs are applied when entering DONE.
- Divide by zero: quotient = all ones, remainder = dividend (unmodified). The same latency applies.
- Overflow (SIGNED=1, dividend = −2^(W−1), divisor = −1): quotient = dividend, remainder = 0.
- `m_axis_dout_tdata` is registered. It holds the last result until the next DONE. Consumers must sample it only while tvalid is high.

## Timing
- Reset values: `m_axis_dout_tvalid=0`, `m_axis_dout_tdata=0`, `busy=0`, state IDLE, all internal registers 0.
- Latency: acceptance at edge 0, CALC during cycles 1..WIDTH, tvalid high during cycle WIDTH+1. That is 33 cycles for WIDTH=32.
- Throughput: one division per WIDTH+2 cycles. The earliest next acceptance is the edge that ends the first IDLE cycle after DONE.
- If upstream drops its valids on the edge that samples tvalid, exactly one result is produced per request.
- Reset asserted mid-operation (any state) forces all reset values immediately, and the operation is lost. No result beat appears after reset release unless a new pair is accepted.

## Structure
- Shared package `div_pkg`: the state enum typedef (IDLE, CALC, DONE) and the localparam for the iteration count width, `$clog2(WIDTH+1)`.
- One sub-module, `div_step`: a combinational single-iteration restoring step. Inputs are the remainder, the quotient, and the divisor magnitude. Outputs are the next remainder and the next quotient. `seq_divider` holds the FSM, counter, sign handling, and special cases.

## Test plan
- 100 / 7 (SIGNED=1): tdata = `{32'd14, 32'd2}`. tvalid is high for exactly one cycle, 33 cycles after the acceptance edge.
- −7 / 2: quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also 7 / −2: 0xFFFFFFFD, 0x00000001. With SIGNED=0, 0xFFFFFFF9 / 2 gives 0x7FFFFFFC, 0x00000001.
- 5 / 0: `{32'hFFFFFFFF, 32'd5}`. 0x80000000 / 0xFFFFFFFF (SIGNED=1): `{32'h80000000, 32'd0}`.
- Handshake:
  - Hold both valids high from acceptance until the edge after tvalid, then drop them: exactly one result and no re-acceptance.
  - Hold only the dividend valid for 10 cycles: no acceptance, `busy` stays 0.
  - Hold both valids high continuously: a new acceptance every 34 cycles.
- Assert `rst_n` low in CALC cycle 10 of a 100 / 7 operation: tvalid, tdata, and busy go to 0 without waiting for a clock edge. After release, 9 / 3 returns `{32'd3, 32'd0}`.
- Back-to-back randomized signed and unsigned operand pairs, including 0, ±1, min, and max, checked against a reference model. The result must arrive at a fixed latency for every pair.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential divider.
package div_pkg;
    localparam int DIV_WIDTH = 32;
    localparam int CNT_W     = $clog2(DIV_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit in, trial subtract.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dmag,
    output logic [WIDTH:0]   rem_nx,
    output logic [WIDTH-1:0] quo_nx
);
    logic [WIDTH:0] r_sh;
    logic           ge;

    // The quotient register doubles as the dividend shifter; its MSB feeds the remainder.
    assign r_sh   = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign ge     = rem[WIDTH] | (r_sh >= {1'b0, dmag});
    assign rem_nx = ge ? r_sh - {1'b0, dmag} : r_sh;
    assign quo_nx = {quo[WIDTH-2:0], ge};
endmodule

// File: rtl/seq_divider.sv
// Fixed-latency radix-2 restoring divider with a dividend/divisor/dout stream interface.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH  = DIV_WIDTH,
    parameter bit SIGNED = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_axis_dividend_tvalid,
    input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
    input  logic               s_axis_divisor_tvalid,
    input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
    output logic               m_axis_dout_tvalid,
    output logic [2*WIDTH-1:0] m_axis_dout_tdata,
    output logic               busy
);
    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo, dmag, dvd;
    logic             q_neg, r_neg, div0, ovf;

    logic [WIDTH:0]   rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, q_fin, r_fin;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem    (rem),
        .quo    (quo),
        .dmag   (dmag),
        .rem_nx (rem_nx),
        .quo_nx (quo_nx)
    );

    // Magnitudes stay WIDTH-bit unsigned so the most negative value maps to 2^(W-1).
    assign a_neg = SIGNED && s_axis_dividend_tdata[WIDTH-1];
    assign b_neg = SIGNED && s_axis_divisor_tdata[WIDTH-1];
    assign a_mag = a_neg ? -s_axis_dividend_tdata : s_axis_dividend_tdata;
    assign b_mag = b_neg ? -s_axis_divisor_tdata  : s_axis_divisor_tdata;

    // Final result is formed from the last iteration's outputs on the CALC->DONE edge.
    always_comb begin
        q_fin = q_neg ? -quo_nx : quo_nx;
        r_fin = r_neg ? -rem_nx[WIDTH-1:0] : rem_nx[WIDTH-1:0];
        if (div0) begin
            q_fin = '1;
            r_fin = dvd;
        end else if (ovf) begin
            q_fin = dvd;
            r_fin = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            cnt                <= '0;
            rem                <= '0;
            quo                <= '0;
            dmag               <= '0;
            dvd                <= '0;
            q_neg              <= 1'b0;
            r_neg              <= 1'b0;
            div0               <= 1'b0;
            ovf                <= 1'b0;
            busy               <= 1'b0;
            m_axis_dout_tvalid <= 1'b0;
            m_axis_dout_tdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_axis_dividend_tvalid && s_axis_divisor_tvalid) begin
                        dvd   <= s_axis_dividend_tdata;
                        dmag  <= b_mag;
                        quo   <= a_mag;
                        rem   <= '0;
                        cnt   <= '0;
                        q_neg <= a_neg ^ b_neg;
                        r_neg <= a_neg;
                        div0  <= (s_axis_divisor_tdata == '0);
                        ovf   <= SIGNED
                                 && (s_axis_dividend_tdata == {1'b1, {(WIDTH-1){1'b0}}})
                                 && (s_axis_divisor_tdata == '1);
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        m_axis_dout_tdata  <= {q_fin, r_fin};
                        m_axis_dout_tvalid <= 1'b1;
                        state              <= DONE;
                    end
                end
                DONE: begin
                    m_axis_dout_tvalid <= 1'b0;
                    busy               <= 1'b0;
                    state              <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
